// File: rtl/mem_arb_pkg.sv
// Shared types, constants and the round-robin pick function for mem_bus_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam int          MAX_REQ       = 8;

    // Returns the first set bit of req at or after ptr, wrapping at n_req.
    // With no request set the result is ptr and must be qualified by the caller.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n_req);
        logic       found;
        logic [2:0] win;
        logic [2:0] idx;
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((32'(ptr) + 32'(k)) % 32'(n_req));
            if (k < n_req && !found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_req
);

    localparam int IDX_W = $clog2(N_REQ);

    always_comb begin
        winner  = IDX_W'(rr_pick(MAX_REQ'(req), 3'(ptr), N_REQ));
        any_req = |req;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between N_REQ requesters.
// Optional macro ARB_TIMEOUT_EN adds a BUSY-state timeout with a sticky bus_err flag.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
    output logic [N_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       m_valid,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    input  logic                       m_ready,
    input  logic [DATA_W-1:0]          m_rdata,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       bus_err
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
    logic [N_REQ-1:0]    req_ready_q, req_ready_d;
    logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;

    logic [IDX_W-1:0]    winner;
    logic                any_req;
    logic                done;
    logic                timed_out;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                bus_err_q, bus_err_d;
`endif

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        m_valid_d   = m_valid_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_wstrb_d   = m_wstrb_q;
        req_ready_d = '0;
        req_rdata_d = req_rdata_q;
        done        = 1'b0;
        timed_out   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        bus_err_d   = bus_err_q;
`endif

        case (state_q)
            ARB_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                if (any_req) begin
                    m_addr_d  = req_addr[32'(winner)*ADDR_W +: ADDR_W];
                    m_wdata_d = req_wdata[32'(winner)*DATA_W +: DATA_W];
                    m_wstrb_d = req_wstrb[32'(winner)*STRB_W +: STRB_W];
                    grant_d   = winner;
                    m_valid_d = 1'b1;
                    state_d   = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                done = m_ready;
`ifdef ARB_TIMEOUT_EN
                if (!m_ready) begin
                    if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        done      = 1'b1;
                        timed_out = 1'b1;
                        bus_err_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
`endif
                if (done) begin
                    m_valid_d            = 1'b0;
                    req_ready_d[grant_q] = 1'b1;
                    if (timed_out)
                        req_rdata_d = DATA_W'(TIMEOUT_RDATA);
                    else if (m_wstrb_q == '0)
                        req_rdata_d = m_rdata;
                    rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            req_ready_q <= '0;
            req_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            req_ready_q <= req_ready_d;
            req_rdata_q <= req_rdata_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign req_rdata = req_rdata_q;
    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign grant_id  = grant_q;
`ifdef ARB_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (N_REQ=2); covers the timeout path when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int STALL_CYC = 12;
`else
    localparam int STALL_CYC = 20;
`endif

    logic                      clk;
    logic                      resetn;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ*DATA_W/8-1:0] req_wstrb;
    logic [N_REQ-1:0]          req_ready;
    logic [DATA_W-1:0]         req_rdata;
    logic                      m_valid;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [DATA_W/8-1:0]       m_wstrb;
    logic                      m_ready;
    logic [DATA_W-1:0]         m_rdata;
    logic [0:0]                grant_id;
    logic                      bus_err;

    int          n_checks;
    int          n_errors;
    logic [31:0] mem_model [0:127];
    int          issued [0:1];

    mem_bus_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .grant_id  (grant_id),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_m_valid(input string tag);
        int budget;
        budget = 0;
        while (m_valid !== 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        check(tag, 64'(m_valid), 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        m_ready   = 1'b0;
        m_rdata   = '0;
        for (int i = 0; i < 128; i++) mem_model[i] = '0;

        // Reset state
        #12;
        check("rst_m_valid",   64'(m_valid),   64'd0);
        check("rst_m_addr",    64'(m_addr),    64'd0);
        check("rst_m_wdata",   64'(m_wdata),   64'd0);
        check("rst_m_wstrb",   64'(m_wstrb),   64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_req_rdata", 64'(req_rdata), 64'd0);
        check("rst_grant_id",  64'(grant_id),  64'd0);
        check("rst_bus_err",   64'(bus_err),   64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // 1. Single read by requester 0
        req_addr[31:0] = 32'h0;
        req_wstrb[3:0] = 4'h0;
        req_valid      = 2'b01;
        tick();
        check("t1_m_valid",  64'(m_valid),   64'd1);
        check("t1_m_addr",   64'(m_addr),    64'h0);
        check("t1_m_wstrb",  64'(m_wstrb),   64'h0);
        check("t1_grant",    64'(grant_id),  64'd0);
        check("t1_no_ready", 64'(req_ready), 64'd0);
        m_ready = 1'b1;
        m_rdata = 32'h0140_0093;
        tick();
        m_ready   = 1'b0;
        m_rdata   = '0;
        req_valid = 2'b00;
        check("t1_ready",     64'(req_ready), 64'b01);
        check("t1_rdata",     64'(req_rdata), 64'h0140_0093);
        check("t1_m_val_off", 64'(m_valid),   64'd0);
        tick();
        check("t1_ready_off", 64'(req_ready), 64'd0);

        // 2. Write by requester 1
        req_addr[63:32]  = 32'h100;
        req_wdata[63:32] = 32'h1E;
        req_wstrb[7:4]   = 4'hF;
        req_valid        = 2'b10;
        tick();
        check("t2_m_addr",  64'(m_addr),   64'h100);
        check("t2_m_wdata", 64'(m_wdata),  64'h1E);
        check("t2_m_wstrb", 64'(m_wstrb),  64'hF);
        check("t2_grant",   64'(grant_id), 64'd1);
        if (m_wstrb != 4'h0) mem_model[m_addr[8:2]] = m_wdata;
        m_ready = 1'b1;
        m_rdata = 32'hBAD0_0001;
        tick();
        m_ready   = 1'b0;
        req_valid = 2'b00;
        check("t2_ready",   64'(req_ready),  64'b10);
        check("t2_rdata",   64'(req_rdata),  64'h0140_0093);
        check("t2_mem64",   64'(mem_model[64]), 64'h1E);
        tick();
        check("t2_ready_off", 64'(req_ready), 64'd0);

        // m_ready while IDLE is ignored
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("idle_mready_ready", 64'(req_ready), 64'd0);
        check("idle_mready_valid", 64'(m_valid),   64'd0);

        // 3. Contention: both requesters valid from reset, three reads each
        req_wstrb = '0;
        #1 resetn = 1'b0;
        req_valid       = 2'b11;
        req_addr[31:0]  = 32'h200;
        req_addr[63:32] = 32'h300;
        issued[0] = 0;
        issued[1] = 0;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 2;
            wait_m_valid($sformatf("t3_wait_%0d", k));
            check($sformatf("t3_grant_%0d", k), 64'(grant_id), 64'(g));
            check($sformatf("t3_addr_%0d", k), 64'(m_addr),
                  64'((g == 0 ? 32'h200 : 32'h300) + 32'(issued[g] * 4)));
            m_ready = 1'b1;
            m_rdata = 32'hC000_0000 + 32'(k);
            tick();
            m_ready = 1'b0;
            check($sformatf("t3_ready_%0d", k), 64'(req_ready), 64'(2'b01 << g));
            check($sformatf("t3_rdata_%0d", k), 64'(req_rdata), 64'(32'hC000_0000 + 32'(k)));
            issued[g]++;
            if (g == 0) req_addr[31:0]  = 32'h200 + 32'(issued[0] * 4);
            else        req_addr[63:32] = 32'h300 + 32'(issued[1] * 4);
            if (issued[g] == 3) req_valid[g] = 1'b0;
        end
        tick();

        // 4. Stall: memory withholds m_ready
        req_addr[31:0] = 32'h40;
        req_valid      = 2'b01;
        tick();
        check("t4_m_valid", 64'(m_valid), 64'd1);
        for (int i = 0; i < STALL_CYC; i++) begin
            tick();
            check($sformatf("t4_stall_%0d", i), {m_valid, m_addr, req_ready},
                  {1'b1, 32'h40, 2'b00});
        end
        m_ready = 1'b1;
        m_rdata = 32'h5A5A_5A5A;
        tick();
        m_ready   = 1'b0;
        req_valid = 2'b00;
        check("t4_ready", 64'(req_ready), 64'b01);
        check("t4_rdata", 64'(req_rdata), 64'h5A5A_5A5A);
        tick();
`ifndef ARB_TIMEOUT_EN
        check("t4_bus_err_tied", 64'(bus_err), 64'd0);
`endif

        // 5. Reset while BUSY; round-robin pointer returns to requester 0
        req_addr[63:32] = 32'h300;
        req_addr[31:0]  = 32'h200;
        req_valid       = 2'b10;
        tick();
        check("t5_busy_grant", 64'(grant_id), 64'd1);
        check("t5_busy_valid", 64'(m_valid),  64'd1);
        resetn = 1'b0;
        #1;
        check("t5_rst_valid", 64'(m_valid),   64'd0);
        check("t5_rst_ready", 64'(req_ready), 64'd0);
        check("t5_rst_grant", 64'(grant_id),  64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        req_valid = 2'b11;
        check("t5_post_ready", 64'(req_ready), 64'd0);
        tick();
        check("t5_first_grant", 64'(grant_id), 64'd0);
        check("t5_first_addr",  64'(m_addr),   64'h200);
        m_ready = 1'b1;
        tick();
        m_ready   = 1'b0;
        req_valid = 2'b10;
        check("t5_ready0", 64'(req_ready), 64'b01);
        wait_m_valid("t5_wait1");
        check("t5_second_grant", 64'(grant_id), 64'd1);
        m_ready = 1'b1;
        tick();
        m_ready   = 1'b0;
        req_valid = 2'b00;
        check("t5_ready1", 64'(req_ready), 64'b10);
        tick();

`ifdef ARB_TIMEOUT_EN
        // 6. Timeout: m_ready never arrives
        req_addr[31:0] = 32'h80;
        req_valid      = 2'b01;
        tick();
        check("t6_m_valid", 64'(m_valid), 64'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("t6_wait_%0d", i), {m_valid, bus_err, req_ready}, {1'b1, 1'b0, 2'b00});
        end
        tick();
        req_valid = 2'b00;
        check("t6_ready",   64'(req_ready), 64'b01);
        check("t6_rdata",   64'(req_rdata), 64'hDEAD_BEEF);
        check("t6_bus_err", 64'(bus_err),   64'd1);
        check("t6_m_valid_off", 64'(m_valid), 64'd0);
        tick();
        check("t6_ready_off", 64'(req_ready), 64'd0);
        tick();
        tick();
        tick();
        check("t6_bus_err_sticky", 64'(bus_err), 64'd1);
        resetn = 1'b0;
        #1;
        check("t6_bus_err_rst", 64'(bus_err), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
